// File: rtl/fft_peak_detector.sv
// 16-bin FFT peak detector: captures a frame per fft_valid strobe,
// scans bin magnitudes (re^2+im^2) one per cycle and reports the max.
module fft_peak_detector #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            done,
  output logic [3:0]      freq,
  output logic [2*DW-1:0] peak_mag,
  output logic            busy,
  output logic            drop
);

  localparam int NBINS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*DW-1:0] r_pend [NBINS];
  logic [2*DW-1:0] r_work [NBINS];
  logic [2*DW-1:0] w_in   [NBINS];
  logic            r_pend_full;
  logic            w_pend_full_nxt;
  logic            w_launch;
  logic            w_drop_nxt;
  logic [3:0]      r_idx;
  logic [3:0]      r_max_idx;
  logic [2*DW-1:0] r_max;
  logic [2*DW-1:0] w_cur;
  logic signed [DW-1:0]   w_re;
  logic signed [DW-1:0]   w_im;
  logic signed [2*DW-1:0] w_re2;
  logic signed [2*DW-1:0] w_im2;
  logic [2*DW-1:0] w_mag;

  assign w_in[0]  = fft_d0;
  assign w_in[1]  = fft_d1;
  assign w_in[2]  = fft_d2;
  assign w_in[3]  = fft_d3;
  assign w_in[4]  = fft_d4;
  assign w_in[5]  = fft_d5;
  assign w_in[6]  = fft_d6;
  assign w_in[7]  = fft_d7;
  assign w_in[8]  = fft_d8;
  assign w_in[9]  = fft_d9;
  assign w_in[10] = fft_d10;
  assign w_in[11] = fft_d11;
  assign w_in[12] = fft_d12;
  assign w_in[13] = fft_d13;
  assign w_in[14] = fft_d14;
  assign w_in[15] = fft_d15;

  // Squared magnitude of the bin under scan; each square is non-negative,
  // so the unsigned sum holds even the -full-scale corner (2^(2DW-1)).
  assign w_cur = r_work[r_idx];
  assign w_re  = w_cur[2*DW-1:DW];
  assign w_im  = w_cur[DW-1:0];
  assign w_re2 = w_re * w_re;
  assign w_im2 = w_im * w_im;
  assign w_mag = $unsigned(w_re2) + $unsigned(w_im2);

  // A pending frame is drained only when the scanner is idle.
  assign w_launch = (r_state == IDLE) && r_pend_full;
  assign w_pend_full_nxt = fft_valid | (r_pend_full & ~w_launch);
  assign w_drop_nxt = fft_valid & r_pend_full & ~w_launch;

  // Next-state logic for the scan sequencer.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (r_pend_full) w_state_nxt = SCAN;
      SCAN:    if (r_idx == 4'd15) w_state_nxt = REPORT;
      REPORT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pending capture and work-buffer hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_full <= 1'b0;
      for (int i = 0; i < NBINS; i++) begin
        r_pend[i] <= '0;
        r_work[i] <= '0;
      end
    end else begin
      r_pend_full <= w_pend_full_nxt;
      for (int i = 0; i < NBINS; i++) begin
        if (fft_valid) r_pend[i] <= w_in[i];
        if (w_launch)  r_work[i] <= r_pend[i];
      end
    end
  end

  // Running maximum; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
    end else if (w_launch) begin
      r_idx     <= '0;
      r_max     <= '0;
      r_max_idx <= '0;
    end else if (r_state == SCAN) begin
      r_idx <= r_idx + 4'd1;
      if (w_mag > r_max) begin
        r_max     <= w_mag;
        r_max_idx <= r_idx;
      end
    end
  end

  // Registered outputs; freq/peak_mag hold between reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done     <= 1'b0;
      freq     <= '0;
      peak_mag <= '0;
      busy     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      done <= (r_state == REPORT);
      drop <= w_drop_nxt;
      busy <= (w_state_nxt != IDLE) | w_pend_full_nxt;
      if (r_state == REPORT) begin
        freq     <= r_max_idx;
        peak_mag <= r_max;
      end
    end
  end

endmodule
